accum_bank: RTL and testbench
=============================

// Module: accum_bank
// PURPOSE
//  Multi-channel signed accumulator; parametrised successor to the single-channel accumulator.
//  Holds NUM_CH independent 2*DATA_WIDTH accumulators with add/subtract, per-channel and global clear.
//  Provides a registered read port and sticky overflow flags.
//  Sits after the multiplier stage in the datapath, one channel per filter tap group.
// PARAMETERS
//  DATA_WIDTH  32  operand half-width; accumulator/addend width ACC_W = 2*DATA_WIDTH
//  NUM_CH      4   number of accumulator channels (>=2); CH_W = $clog2(NUM_CH)
// PORTS
//  Clk        in   1      clock, all logic on posedge
//  Rst_n      in   1      synchronous, active-low reset
//  in_valid   in   1      addend offered
//  in_ready   out  1      addend accepted when in_valid & in_ready
//  in_ch      in   CH_W   target channel
//  in_sub     in   1      1: acc -= addend, 0: acc += addend
//  in_addend  in   ACC_W  two's-complement addend
//  clr_valid  in   1      single-channel clear request (one cycle, no handshake)
//  clr_ch     in   CH_W   channel to clear
//  clr_all    in   1      start global clear sweep (pulse)
//  rd_req     in   1      read request
//  rd_ch      in   CH_W   channel to read
//  rd_valid   out  1      rd_data/rd_ovf valid (1 cycle after rd_req)
//  rd_data    out  ACC_W  accumulator value
//  rd_ovf     out  1      sticky overflow flag of read channel
//  ovf        out  NUM_CH sticky overflow flags, all channels
//  busy       out  1      high during clear sweep
// BEHAVIOUR
//  Reset (Rst_n=0 at posedge): all acc=0, ovf=0, rd_valid=0, rd_data=0, rd_ovf=0, busy=0, state=ST_IDLE.
//  FSM: ST_IDLE -> ST_SWEEP on clr_all; ST_SWEEP clears channel sweep_idx per cycle, 0..NUM_CH-1;
//   -> ST_IDLE after clearing NUM_CH-1 (sweep takes exactly NUM_CH cycles). clr_all during sweep ignored.
//  busy = (state==ST_SWEEP). in_ready = (state==ST_IDLE) & ~clr_valid & ~clr_all (combinational).
//  Accepted addend updates acc[in_ch] at the same edge; result visible next cycle (latency 1).
//  Arithmetic: full ACC_W signed add/sub; overflow = operand signs equal (after negation for sub) and
//   result sign differs. Overflow sets ovf[ch] (sticky). Subtracting the most-negative value counts as overflow.
//  clr_valid in ST_IDLE: acc[clr_ch]=0, ovf[clr_ch]=0. clr_valid in ST_SWEEP ignored.
//  clr_valid and clr_all in the same cycle: clr_all wins.
//  Read: rd_data/rd_ovf register acc[rd_ch]/ovf[rd_ch] as held BEFORE that edge's update.
//   Same-cycle add/clear to rd_ch returns the old value. rd_valid = rd_req delayed by 1.
//   Reads are allowed during the sweep.
//  rd_ch/in_ch/clr_ch >= NUM_CH (non-power-of-2 NUM_CH): write dropped, read returns 0/0.
//  Reset mid-sweep aborts the sweep; all state returns to its reset values.
// CONFIGURATION
//  ACCUM_SATURATE_EN defined: on overflow, clamp to +2^(ACC_W-1)-1 or -2^(ACC_W-1); ovf still set.
//  Not defined: result wraps modulo 2^ACC_W; ovf still set.
// STRUCTURE
//  Package accum_bank_pkg: state_t enum {ST_IDLE, ST_SWEEP}; ACC_MAX/ACC_MIN constant functions of width.
//  Sub-module accum_sat_add (combinational):
//   a, b, sub -> sum, ovf. Contains the ACCUM_SATURATE_EN clamp.
//  Top holds the register array, the FSM, the read pipeline and the handshake.
// TESTING (DATA_WIDTH=8, ACC_W=16, NUM_CH=4)
//  Add 100, 200, -50 to ch1, read ch1 -> rd_valid next cycle, rd_data=250, others 0, ovf=0.
//  ch2 = 0x7FF0, add 0x20 -> wrap build 0x8010, ovf[2]=1; SATURATE_EN build 0x7FFF, ovf[2]=1.
//  in_sub=1, addend 0x8000 on ch0=0 -> ovf[0]=1; clr_valid ch0 -> ch0=0, ovf[0]=0.
//  clr_all with ch0..3 nonzero -> busy 4 cycles, in_ready=0 throughout, all acc=0, ovf=0 after.
//  Add to ch3 and rd_ch=3 in the same cycle (ch3=5, addend 7) -> rd_data=5; next read=12.
//  Rst_n=0 for 1 cycle mid-sweep -> busy=0, all outputs 0, in_ready=1 next cycle.

Source files
------------

// File: rtl/accum_bank_pkg.sv
// Shared types and limit helpers for the multi-channel accumulator bank.
package accum_bank_pkg;

  typedef enum logic {ST_IDLE, ST_SWEEP} state_t;

  localparam int unsigned MAX_W = 128;

  // Largest positive two's-complement value of width w, zero-extended to MAX_W.
  function automatic logic [MAX_W-1:0] acc_max(input int unsigned w);
    logic [MAX_W-1:0] v;
    v = '0;
    for (int unsigned i = 0; i + 1 < w; i++) v[i] = 1'b1;
    return v;
  endfunction

  // Most-negative two's-complement value of width w, zero-extended to MAX_W.
  function automatic logic [MAX_W-1:0] acc_min(input int unsigned w);
    logic [MAX_W-1:0] v;
    v = '0;
    v[w-1] = 1'b1;
    return v;
  endfunction

endpackage

// File: rtl/accum_sat_add.sv
// Combinational signed add/subtract with overflow detect.
// ACCUM_SATURATE_EN selects clamping on overflow; otherwise the result wraps.
module accum_sat_add
  import accum_bank_pkg::*;
#(
  parameter int unsigned W = 64
) (
  input  logic [W-1:0] i_a,
  input  logic [W-1:0] i_b,
  input  logic         i_sub,
  output logic [W-1:0] o_sum,
  output logic         o_ovf
);

  localparam logic [MAX_W-1:0] MaxFull = acc_max(W);
  localparam logic [MAX_W-1:0] MinFull = acc_min(W);
  localparam logic [W-1:0]     AccMax  = MaxFull[W-1:0];
  localparam logic [W-1:0]     AccMin  = MinFull[W-1:0];

  logic [W-1:0] w_b_eff;
  logic [W-1:0] w_raw;
  logic         w_b_min;

  assign w_b_eff = i_sub ? (~i_b + W'(1)) : i_b;
  assign w_raw   = i_a + w_b_eff;
  assign w_b_min = (i_b == AccMin);

  // Negating the most-negative value is itself unrepresentable, so always flag it.
  assign o_ovf = ((i_a[W-1] == w_b_eff[W-1]) && (w_raw[W-1] != i_a[W-1])) ||
                 (i_sub && w_b_min);

`ifdef ACCUM_SATURATE_EN
  logic w_pos;
  assign w_pos = (i_sub && w_b_min) || !i_a[W-1];
  assign o_sum = o_ovf ? (w_pos ? AccMax : AccMin) : w_raw;
`else
  assign o_sum = w_raw;
`endif

endmodule

// File: rtl/accum_bank.sv
// Multi-channel signed accumulator bank with clear sweep, registered read port and sticky ovf.
// Build with ACCUM_SATURATE_EN to clamp on overflow instead of wrapping.
module accum_bank
  import accum_bank_pkg::*;
#(
  parameter int unsigned DATA_WIDTH = 32,
  parameter int unsigned NUM_CH     = 4,
  localparam int unsigned ACC_W     = 2 * DATA_WIDTH,
  localparam int unsigned CH_W      = $clog2(NUM_CH)
) (
  input  logic              Clk,
  input  logic              Rst_n,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [CH_W-1:0]   in_ch,
  input  logic              in_sub,
  input  logic [ACC_W-1:0]  in_addend,
  input  logic              clr_valid,
  input  logic [CH_W-1:0]   clr_ch,
  input  logic              clr_all,
  input  logic              rd_req,
  input  logic [CH_W-1:0]   rd_ch,
  output logic              rd_valid,
  output logic [ACC_W-1:0]  rd_data,
  output logic              rd_ovf,
  output logic [NUM_CH-1:0] ovf,
  output logic              busy
);

  localparam logic [CH_W:0]   NumChL  = (CH_W + 1)'(NUM_CH);
  localparam logic [CH_W-1:0] LastIdx = CH_W'(NUM_CH - 1);

  logic [ACC_W-1:0]  r_acc [NUM_CH];
  logic [ACC_W-1:0]  w_acc_d [NUM_CH];
  logic [NUM_CH-1:0] r_ovf, w_ovf_d;
  state_t            r_state, w_state_d;
  logic [CH_W-1:0]   r_sweep_idx, w_sweep_idx_d;
  logic              r_rd_valid, r_rd_ovf;
  logic [ACC_W-1:0]  r_rd_data;

  logic              w_in_ok, w_rd_ok, w_accept, w_add_ovf;
  logic [ACC_W-1:0]  w_acc_sel, w_sum;

  assign w_in_ok   = ({1'b0, in_ch} < NumChL);
  assign w_rd_ok   = ({1'b0, rd_ch} < NumChL);
  assign in_ready  = (r_state == ST_IDLE) & ~clr_valid & ~clr_all;
  assign w_accept  = in_valid & in_ready;
  assign w_acc_sel = w_in_ok ? r_acc[in_ch] : '0;

  accum_sat_add #(
    .W (ACC_W)
  ) u_add (
    .i_a   (w_acc_sel),
    .i_b   (in_addend),
    .i_sub (in_sub),
    .o_sum (w_sum),
    .o_ovf (w_add_ovf)
  );

  always_comb begin
    w_state_d     = r_state;
    w_sweep_idx_d = r_sweep_idx;
    unique case (r_state)
      ST_IDLE: begin
        w_sweep_idx_d = '0;
        if (clr_all) w_state_d = ST_SWEEP;
      end
      ST_SWEEP: begin
        w_sweep_idx_d = r_sweep_idx + CH_W'(1);
        if (r_sweep_idx == LastIdx) w_state_d = ST_IDLE;
      end
      default: w_state_d = ST_IDLE;
    endcase
  end

  // Out-of-range channel indices match no slot, so those writes fall away.
  always_comb begin
    w_acc_d = r_acc;
    w_ovf_d = r_ovf;
    for (int i = 0; i < int'(NUM_CH); i++) begin
      if (r_state == ST_SWEEP) begin
        if (r_sweep_idx == CH_W'(i)) begin
          w_acc_d[i] = '0;
          w_ovf_d[i] = 1'b0;
        end
      end else if (clr_all) begin
        w_acc_d[i] = r_acc[i];
      end else if (clr_valid) begin
        if (clr_ch == CH_W'(i)) begin
          w_acc_d[i] = '0;
          w_ovf_d[i] = 1'b0;
        end
      end else if (w_accept && (in_ch == CH_W'(i))) begin
        w_acc_d[i] = w_sum;
        if (w_add_ovf) w_ovf_d[i] = 1'b1;
      end
    end
  end

  always_ff @(posedge Clk) begin
    if (!Rst_n) begin
      r_state     <= ST_IDLE;
      r_sweep_idx <= '0;
      r_ovf       <= '0;
      r_rd_valid  <= 1'b0;
      r_rd_data   <= '0;
      r_rd_ovf    <= 1'b0;
      for (int i = 0; i < int'(NUM_CH); i++) r_acc[i] <= '0;
    end else begin
      r_state     <= w_state_d;
      r_sweep_idx <= w_sweep_idx_d;
      r_ovf       <= w_ovf_d;
      r_rd_valid  <= rd_req;
      for (int i = 0; i < int'(NUM_CH); i++) r_acc[i] <= w_acc_d[i];
      // Read samples pre-edge contents so a same-cycle write returns the old value.
      if (rd_req) begin
        r_rd_data <= w_rd_ok ? r_acc[rd_ch] : '0;
        r_rd_ovf  <= w_rd_ok ? r_ovf[rd_ch] : 1'b0;
      end
    end
  end

  assign busy     = (r_state == ST_SWEEP);
  assign ovf      = r_ovf;
  assign rd_valid = r_rd_valid;
  assign rd_data  = r_rd_data;
  assign rd_ovf   = r_rd_ovf;

endmodule

// File: tb/tb_accum_bank.sv
// Directed bench for accum_bank (DATA_WIDTH=8, NUM_CH=4); honours ACCUM_SATURATE_EN.
module tb_accum_bank;

  logic        Clk;
  logic        Rst_n;
  logic        in_valid;
  logic        in_ready;
  logic [1:0]  in_ch;
  logic        in_sub;
  logic [15:0] in_addend;
  logic        clr_valid;
  logic [1:0]  clr_ch;
  logic        clr_all;
  logic        rd_req;
  logic [1:0]  rd_ch;
  logic        rd_valid;
  logic [15:0] rd_data;
  logic        rd_ovf;
  logic [3:0]  ovf;
  logic        busy;

  int total = 0;
  int bad   = 0;

  accum_bank #(
    .DATA_WIDTH (8),
    .NUM_CH     (4)
  ) dut (
    .Clk       (Clk),
    .Rst_n     (Rst_n),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_ch     (in_ch),
    .in_sub    (in_sub),
    .in_addend (in_addend),
    .clr_valid (clr_valid),
    .clr_ch    (clr_ch),
    .clr_all   (clr_all),
    .rd_req    (rd_req),
    .rd_ch     (rd_ch),
    .rd_valid  (rd_valid),
    .rd_data   (rd_data),
    .rd_ovf    (rd_ovf),
    .ovf       (ovf),
    .busy      (busy)
  );

  initial Clk = 1'b0;
  always #5 Clk = ~Clk;

  task automatic tick();
    @(posedge Clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    total++;
    assert (obs === exp)
    else begin
      bad++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic do_add(input logic [1:0] ch, input logic sub, input logic [15:0] val);
    in_valid  = 1'b1;
    in_ch     = ch;
    in_sub    = sub;
    in_addend = val;
    tick();
    in_valid  = 1'b0;
    in_sub    = 1'b0;
  endtask

  task automatic do_read(input logic [1:0] ch);
    rd_req = 1'b1;
    rd_ch  = ch;
    tick();
    rd_req = 1'b0;
  endtask

  logic [15:0] exp_wrap2, exp_sub0;

  initial begin
`ifdef ACCUM_SATURATE_EN
    exp_wrap2 = 16'h7FFF;
    exp_sub0  = 16'h7FFF;
`else
    exp_wrap2 = 16'h8010;
    exp_sub0  = 16'h8000;
`endif
    Rst_n = 1'b0; in_valid = 1'b0; in_ch = '0; in_sub = 1'b0; in_addend = '0;
    clr_valid = 1'b0; clr_ch = '0; clr_all = 1'b0; rd_req = 1'b0; rd_ch = '0;
    tick();
    tick();
    Rst_n = 1'b1;
    check("rst_busy", 16'(busy), 16'd0);
    check("rst_ovf", 16'(ovf), 16'd0);
    check("rst_rd_valid", 16'(rd_valid), 16'd0);
    check("rst_rd_data", rd_data, 16'd0);
    check("rst_in_ready", 16'(in_ready), 16'd1);

    // 100 + 200 - 50 on ch1
    do_add(2'd1, 1'b0, 16'd100);
    do_add(2'd1, 1'b0, 16'd200);
    do_add(2'd1, 1'b0, 16'hFFCE);
    do_read(2'd1);
    check("rd1_valid", 16'(rd_valid), 16'd1);
    check("rd1_data", rd_data, 16'd250);
    tick();
    check("rd_valid_drop", 16'(rd_valid), 16'd0);
    do_read(2'd0);
    check("rd0_zero", rd_data, 16'd0);
    do_read(2'd3);
    check("rd3_zero", rd_data, 16'd0);
    check("ovf_none", 16'(ovf), 16'd0);

    // Positive overflow on ch2
    do_add(2'd2, 1'b0, 16'h7FF0);
    check("ovf_before_wrap", 16'(ovf), 16'd0);
    do_add(2'd2, 1'b0, 16'h0020);
    check("ovf2_set", 16'(ovf), 16'b0100);
    do_read(2'd2);
    check("rd2_overflow_val", rd_data, exp_wrap2);
    check("rd2_ovf", 16'(rd_ovf), 16'd1);

    // Subtract most-negative from zero, then single-channel clear
    do_add(2'd0, 1'b1, 16'h8000);
    check("ovf0_sub_min", 16'(ovf), 16'b0101);
    do_read(2'd0);
    check("rd0_sub_min", rd_data, exp_sub0);
    check("rd0_ovf", 16'(rd_ovf), 16'd1);
    clr_valid = 1'b1;
    clr_ch    = 2'd0;
    #1;
    check("in_ready_clr", 16'(in_ready), 16'd0);
    tick();
    clr_valid = 1'b0;
    check("ovf0_cleared", 16'(ovf), 16'b0100);
    do_read(2'd0);
    check("rd0_cleared", rd_data, 16'd0);
    check("rd0_ovf_cleared", 16'(rd_ovf), 16'd0);

    // Global sweep with all channels nonzero; addend offered during sweep must drop
    do_add(2'd0, 1'b0, 16'd1);
    do_add(2'd3, 1'b0, 16'd3);
    clr_all = 1'b1;
    #1;
    check("in_ready_clr_all", 16'(in_ready), 16'd0);
    tick();
    clr_all   = 1'b0;
    in_valid  = 1'b1;
    in_ch     = 2'd1;
    in_addend = 16'd9;
    for (int k = 0; k < 4; k++) begin
      check($sformatf("sweep_busy%0d", k), 16'(busy), 16'd1);
      check($sformatf("sweep_ready%0d", k), 16'(in_ready), 16'd0);
      tick();
    end
    in_valid = 1'b0;
    check("sweep_done_busy", 16'(busy), 16'd0);
    check("sweep_done_ovf", 16'(ovf), 16'd0);
    for (int c = 0; c < 4; c++) begin
      do_read(2'(c));
      check($sformatf("sweep_rd%0d", c), rd_data, 16'd0);
    end

    // Same-cycle add and read return the old value
    do_add(2'd3, 1'b0, 16'd5);
    rd_req = 1'b1;
    rd_ch  = 2'd3;
    do_add(2'd3, 1'b0, 16'd7);
    rd_req = 1'b0;
    check("rd3_old", rd_data, 16'd5);
    do_read(2'd3);
    check("rd3_new", rd_data, 16'd12);

    // Reset in the middle of a sweep
    do_add(2'd1, 1'b0, 16'd1);
    do_add(2'd2, 1'b0, 16'h7FFF);
    do_add(2'd2, 1'b0, 16'h7FFF);
    check("ovf2_pre_rst", 16'(ovf), 16'b0100);
    clr_all = 1'b1;
    tick();
    clr_all = 1'b0;
    check("midsweep_busy", 16'(busy), 16'd1);
    Rst_n = 1'b0;
    tick();
    Rst_n = 1'b1;
    check("abort_busy", 16'(busy), 16'd0);
    check("abort_ovf", 16'(ovf), 16'd0);
    check("abort_rd_data", rd_data, 16'd0);
    check("abort_rd_valid", 16'(rd_valid), 16'd0);
    check("abort_rd_ovf", 16'(rd_ovf), 16'd0);
    check("abort_in_ready", 16'(in_ready), 16'd1);
    do_read(2'd3);
    check("abort_rd3", rd_data, 16'd0);
    do_read(2'd1);
    check("abort_rd1", rd_data, 16'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
